fpu_cw_access_arbiter: RTL

- Shares the FPU control-word register port (cs, data_in, wr_en, ack, word_out) between two requesters: the CPU I/O path (FLDCW/FSTCW) and the FPU microcode sequencer (FLDENV/FSTENV).
- Also sequences the FINIT default-load.
- Sits between the bus/microcode engines and the control register, and owns all register accesses.
- Runs one transaction at a time, with a round-robin grant, an ack handshake and an ack-timeout error.

---
 rtl/fpu_cw_access_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fpu_cw_access_arbiter.sv
// fpu_cw_access_arbiter
// Owns the single FPU control-word register port and shares it between the
// CPU I/O path (FLDCW/FSTCW), the microcode sequencer (FLDENV/FSTENV) and
// the FINIT default-load. One transaction is in flight at a time. FINIT has
// priority, and the two requesters alternate round-robin when both are
// waiting. A register that never acks is abandoned after ACK_TIMEOUT cycles,
// and the requester still gets its ack, flagged by err.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   finit                   one-cycle pulse requesting a DEFAULT_CW load
//   cpu_req/wr/wdata        CPU request (level, held until cpu_ack)
//   cpu_ack/rdata           CPU completion pulse, captured control word
//   uc_req/wr/wdata         microcode request, same protocol as CPU
//   uc_ack/rdata            microcode completion pulse, captured word
//   err                     pulses together with the ack of a timed-out txn
//   busy                    arbiter is not idle
//   cw_cs/wr_en/data_out    register access strobe, write enable, write data
//   cw_ack, cw_word_in      register ack (registered), current control word
module fpu_cw_access_arbiter #(
    parameter logic [15:0] DEFAULT_CW  = 16'h037F,
    parameter int          ACK_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        finit,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        uc_req,
    input  logic        uc_wr,
    input  logic [15:0] uc_wdata,
    output logic        uc_ack,
    output logic [15:0] uc_rdata,
    output logic        err,
    output logic        busy,
    output logic        cw_cs,
    output logic        cw_wr_en,
    output logic [15:0] cw_data_out,
    input  logic        cw_ack,
    input  logic [15:0] cw_word_in
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Owner codes double as the requester index for CPU (0) and UC (1).
    localparam logic [1:0] OWN_CPU   = 2'd0;
    localparam logic [1:0] OWN_UC    = 2'd1;
    localparam logic [1:0] OWN_FINIT = 2'd2;

    localparam int NUM_REQ = 2;

    typedef struct packed {
        logic [1:0]  owner;
        logic        wr;
        logic [15:0] wdata;
    } txn_t;

    logic [1:0]  state;
    txn_t        txn_q;
    txn_t        sel;
    logic        sel_vld;
    logic        finit_pending;
    logic        last_uc;      // 1: microcode owned the last served request
    logic        err_flag;
    logic [7:0]  tmo_cnt;

    logic [NUM_REQ-1:0][15:0] rdata_q;

    // IDLE selection: pending FINIT first, then the lone requester, and on a
    // tie the requester that was not served last.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        if (finit_pending) begin
            sel_vld   = 1'b1;
            sel.owner = OWN_FINIT;
            sel.wr    = 1'b1;
            sel.wdata = DEFAULT_CW;
        end else if (cpu_req && (!uc_req || last_uc)) begin
            sel_vld   = 1'b1;
            sel.owner = OWN_CPU;
            sel.wr    = cpu_wr;
            sel.wdata = cpu_wdata;
        end else if (uc_req) begin
            sel_vld   = 1'b1;
            sel.owner = OWN_UC;
            sel.wr    = uc_wr;
            sel.wdata = uc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            txn_q         <= '0;
            finit_pending <= 1'b0;
            last_uc       <= 1'b1;
            err_flag      <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            // A new finit in the same cycle as the clear keeps pending set.
            finit_pending <= finit |
                             (finit_pending & ~(state == S_IDLE));
            case (state)
                S_IDLE: begin
                    err_flag <= 1'b0;
                    if (sel_vld) begin
                        txn_q <= sel;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    tmo_cnt <= 8'(ACK_TIMEOUT - 1);
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (cw_ack) begin
                        state <= S_DONE;
                    end else if (tmo_cnt == '0) begin
                        err_flag <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 8'd1;
                    end
                end
                default: begin
                    // FINIT leaves the round-robin pointer alone.
                    if (txn_q.owner != OWN_FINIT)
                        last_uc <= (txn_q.owner == OWN_UC);
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Per-requester read-data capture; a timed-out transaction never gets
    // here because cw_ack was not seen.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rdata
        always_ff @(posedge clk) begin
            if (reset)
                rdata_q[g] <= '0;
            else if (state == S_WAIT && cw_ack && txn_q.owner == 2'(g))
                rdata_q[g] <= cw_word_in;
        end
    end

    assign cpu_rdata   = rdata_q[OWN_CPU];
    assign uc_rdata    = rdata_q[OWN_UC];

    assign busy        = (state != S_IDLE);
    assign cw_cs       = (state == S_GRANT) || (state == S_WAIT);
    assign cw_wr_en    = cw_cs & txn_q.wr;
    assign cw_data_out = cw_cs ? txn_q.wdata : '0;

    assign cpu_ack     = (state == S_DONE) && (txn_q.owner == OWN_CPU);
    assign uc_ack      = (state == S_DONE) && (txn_q.owner == OWN_UC);
    assign err         = (state == S_DONE) && err_flag;

endmodule
